// File: rtl/piece_geometry_unit.sv
// Tetromino geometry engine: holds the active piece (type, rotation, origin), takes load/rotate/redraw
// commands over valid/ready and then streams the four absolute board cells, one per cell handshake.
module piece_geometry_unit #(
  parameter int COORD_W = 5
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd,
  input  logic [2:0]         block,
  input  logic [COORD_W-1:0] origin_x,
  input  logic [COORD_W-1:0] origin_y,
  output logic               cell_valid,
  input  logic               cell_ready,
  output logic [COORD_W-1:0] cell_x,
  output logic [COORD_W-1:0] cell_y,
  output logic [1:0]         cell_idx,
  output logic               cell_last,
  output logic [5:0]         colour,
  output logic [1:0]         rotation,
  output logic               loaded,
  output logic               err,
  output logic               fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid never waits on ready,
  // and the payload of a presented cell holds until it is taken.
  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  localparam logic [1:0] CMD_LOAD = 2'b00;
  localparam logic [1:0] CMD_CW   = 2'b01;
  localparam logic [1:0] CMD_CCW  = 2'b10;

  state_t               state_q, state_d;
  logic [2:0]           blk_q;
  logic [COORD_W-1:0]   ox_q, oy_q;
  logic [1:0]           rot_q, idx_q;
  logic                 loaded_q, err_q;
  logic                 accept, reject;
  logic [1:0]           off_x, off_y, box_m1, tmp;
  logic [3:0]           base;

  // Base cell of a piece at rotation 0, packed {x[1:0], y[1:0]}; cell i sits at bits [4i +: 4].
  function automatic logic [3:0] base_cell(input logic [2:0] b, input logic [1:0] i);
    logic [15:0] tbl;
    case (b)
      3'd0:    tbl = 16'b1101_1001_0101_0001; // I
      3'd1:    tbl = 16'b1001_0101_0001_0000; // J
      3'd2:    tbl = 16'b1001_0101_0001_1000; // L
      3'd3:    tbl = 16'b0101_0001_0100_0000; // O
      3'd4:    tbl = 16'b0101_0001_1000_0100; // S
      3'd5:    tbl = 16'b1001_0101_0001_0100; // T
      3'd6:    tbl = 16'b1001_0101_0100_0000; // Z
      default: tbl = 16'b0;
    endcase
    return tbl[{i, 2'b00} +: 4];
  endfunction

  function automatic logic [5:0] piece_colour(input logic [2:0] b);
    case (b)
      3'd0:    return 6'b001111;
      3'd1:    return 6'b000011;
      3'd2:    return 6'b111000;
      3'd3:    return 6'b111100;
      3'd4:    return 6'b001100;
      3'd5:    return 6'b110011;
      3'd6:    return 6'b110000;
      default: return 6'b000000;
    endcase
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    reject  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if ((cmd == CMD_LOAD) ? (block != 3'd7) : loaded_q) accept = 1'b1;
          else                                                 reject = 1'b1;
        end
        if (accept) state_d = EMIT;
      end
      EMIT: begin
        if (cell_ready && idx_q == 2'd3) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      blk_q    <= 3'd0;
      ox_q     <= '0;
      oy_q     <= '0;
      rot_q    <= 2'd0;
      idx_q    <= 2'd0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= reject;
      if (accept) begin
        case (cmd)
          CMD_LOAD: begin
            blk_q    <= block;
            ox_q     <= origin_x;
            oy_q     <= origin_y;
            rot_q    <= 2'd0;
            loaded_q <= 1'b1;
          end
          CMD_CW:  rot_q <= rot_q + 2'd1;
          CMD_CCW: rot_q <= rot_q - 2'd1;
          default: ;
        endcase
      end
      // idx wraps 3 -> 0 on the last handshake, so the next stream starts at cell 0.
      if (state_q == EMIT && cell_ready) idx_q <= idx_q + 2'd1;
    end
  end

  // Offset within the N x N box: one CW step maps (x,y) to (N-1-y, x), applied rot_q times.
  always_comb begin
    base   = base_cell(blk_q, idx_q);
    box_m1 = (blk_q == 3'd0) ? 2'd3 : (blk_q == 3'd3) ? 2'd1 : 2'd2;
    off_x  = base[3:2];
    off_y  = base[1:0];
    tmp    = 2'd0;
    for (int k = 0; k < 3; k++) begin
      if (k < int'(rot_q)) begin
        tmp   = off_x;
        off_x = box_m1 - off_y;
        off_y = tmp;
      end
    end
  end

  assign cell_valid = (state_q == EMIT);
  assign cmd_ready  = (state_q == IDLE);
  assign cell_x     = cell_valid ? ox_q + {{(COORD_W-2){1'b0}}, off_x} : '0;
  assign cell_y     = cell_valid ? oy_q + {{(COORD_W-2){1'b0}}, off_y} : '0;
  assign cell_idx   = idx_q;
  assign cell_last  = cell_valid && (idx_q == 2'd3);
  assign colour     = loaded_q ? piece_colour(blk_q) : 6'd0;
  assign rotation   = rot_q;
  assign loaded     = loaded_q;
  assign err        = err_q;
  assign fsm_state  = state_q;

endmodule

// File: tb/tb_piece_geometry_unit.sv
// Bench for piece_geometry_unit: directed vector table, stall/reset sequence, and random commands
// checked against a tetromino model built from base cells and the rotation rule.
module tb_piece_geometry_unit;
  localparam int CW = 5;
  localparam int EW = 2 * CW + 3;

  logic          clk, resetn, cmd_valid, cmd_ready, cell_valid, cell_ready;
  logic [1:0]    cmd, cell_idx, rotation;
  logic [2:0]    block;
  logic [CW-1:0] origin_x, origin_y, cell_x, cell_y;
  logic          cell_last, loaded, err, fsm_state;
  logic [5:0]    colour;

  piece_geometry_unit #(.COORD_W(CW)) dut (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .block(block), .origin_x(origin_x), .origin_y(origin_y), .cell_valid(cell_valid),
    .cell_ready(cell_ready), .cell_x(cell_x), .cell_y(cell_y), .cell_idx(cell_idx),
    .cell_last(cell_last), .colour(colour), .rotation(rotation), .loaded(loaded), .err(err),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  // ---------------- reference model ----------------
  int base_x [7][4] = '{'{0,1,2,3}, '{0,0,1,2}, '{2,0,1,2}, '{0,1,0,1}, '{1,2,0,1}, '{1,0,1,2}, '{0,1,1,2}};
  int base_y [7][4] = '{'{1,1,1,1}, '{0,1,1,1}, '{0,1,1,1}, '{0,0,1,1}, '{0,0,1,1}, '{0,1,1,1}, '{0,0,1,1}};
  int box_n  [7]    = '{4, 3, 3, 2, 3, 3, 3};
  int colour_tab [7] = '{'h0F, 'h03, 'h38, 'h3C, 'h0C, 'h33, 'h30};
  int m_blk, m_rot, m_loaded, m_ox, m_oy;

  function automatic logic [EW-1:0] pack(input int x, input int y, input int i);
    logic [CW-1:0] xv, yv;
    logic [1:0] iv;
    xv = x[CW-1:0];
    yv = y[CW-1:0];
    iv = i[1:0];
    return {xv, yv, iv, (i == 3)};
  endfunction

  task automatic model_reset();
    m_blk = 0; m_rot = 0; m_loaded = 0; m_ox = 0; m_oy = 0;
  endtask

  function automatic bit model_accepts(input int c, input int b);
    return (c == 0) ? (b != 7) : (m_loaded != 0);
  endfunction

  task automatic model_apply(input int c, input int b, input int ox, input int oy);
    case (c)
      0: begin m_blk = b; m_ox = ox; m_oy = oy; m_rot = 0; m_loaded = 1; end
      1: m_rot = (m_rot + 1) % 4;
      2: m_rot = (m_rot + 3) % 4;
      default: ;
    endcase
  endtask

  task automatic push_model_cells();
    int x, y, t;
    for (int i = 0; i < 4; i++) begin
      x = base_x[m_blk][i];
      y = base_y[m_blk][i];
      repeat (m_rot) begin
        t = x; x = box_n[m_blk] - 1 - y; y = t;
      end
      exp_q.push_back(pack((m_ox + x) % (1 << CW), (m_oy + y) % (1 << CW), i));
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] cell_now();
    return {cell_x, cell_y, cell_idx, cell_last};
  endfunction

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic issue(input int c, input int b, input int ox, input int oy);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd = c[1:0]; block = b[2:0];
    origin_x = ox[CW-1:0]; origin_y = oy[CW-1:0];
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_stream(input bit rand_ready, input int exp_rot, input int exp_col);
    int budget;
    logic [EW-1:0] e;
    budget = 200;
    chk("cell_valid_latency", cell_valid, 1);
    chk("cmd_ready_emit", cmd_ready, 0);
    chk("rotation", rotation, exp_rot);
    chk("loaded", loaded, 1);
    chk("colour", colour, exp_col);
    while (exp_q.size() > 0 && budget > 0) begin
      cell_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cell_valid && cell_ready) begin
        e = exp_q.pop_front();
        chk("cell", cell_now(), e);
      end
      @(posedge clk); #1;
      budget--;
    end
    cell_ready = 1'b0;
    chk("stream_cells_left", exp_q.size(), 0);
    exp_q.delete();
    chk("cmd_ready_after", cmd_ready, 1);
    chk("cell_valid_after", cell_valid, 0);
  endtask

  task automatic expect_reject(input int exp_loaded, input int exp_rot);
    chk("err_pulse", err, 1);
    chk("no_valid_on_reject", cell_valid, 0);
    chk("loaded_kept", loaded, exp_loaded);
    chk("rotation_kept", rotation, exp_rot);
    @(posedge clk); #1;
    chk("err_one_cycle", err, 0);
    chk("no_valid_after_reject", cell_valid, 0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    int c, b, ox, oy, rot, col;
    int x0, y0, x1, y1, x2, y2, x3, y3;
  } vec_t;
  vec_t vecs[$];

  task automatic do_reset();
    resetn = 1'b0;
    cmd_valid = 1'b0; cell_ready = 1'b0; cmd = 2'd0; block = 3'd0;
    origin_x = '0; origin_y = '0;
    #12;
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    model_reset();
  endtask

  initial begin
    int c, b, ox, oy;
    vec_t v;

    vecs.push_back('{0, 5, 4, 0, 0, 'h33, 5, 0, 4, 1, 5, 1, 6, 1});
    vecs.push_back('{1, 0, 0, 0, 1, 'h33, 6, 1, 5, 0, 5, 1, 5, 2});
    vecs.push_back('{2, 0, 0, 0, 0, 'h33, 5, 0, 4, 1, 5, 1, 6, 1});
    vecs.push_back('{3, 0, 0, 0, 0, 'h33, 5, 0, 4, 1, 5, 1, 6, 1});
    vecs.push_back('{0, 0, 2, 3, 0, 'h0F, 2, 4, 3, 4, 4, 4, 5, 4});
    vecs.push_back('{1, 0, 0, 0, 1, 'h0F, 4, 3, 4, 4, 4, 5, 4, 6});
    vecs.push_back('{1, 0, 0, 0, 2, 'h0F, 5, 5, 4, 5, 3, 5, 2, 5});
    vecs.push_back('{1, 0, 0, 0, 3, 'h0F, 3, 6, 3, 5, 3, 4, 3, 3});
    vecs.push_back('{1, 0, 0, 0, 0, 'h0F, 2, 4, 3, 4, 4, 4, 5, 4});
    vecs.push_back('{0, 0, 30, 31, 0, 'h0F, 30, 0, 31, 0, 0, 0, 1, 0});

    resetn = 1'b0;
    cmd_valid = 1'b0; cell_ready = 1'b0; cmd = 2'd0; block = 3'd0;
    origin_x = '0; origin_y = '0;
    #7;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_cell_valid", cell_valid, 0);
    chk("rst_cell_xy", {cell_x, cell_y}, 0);
    chk("rst_idx_last", {cell_idx, cell_last}, 0);
    chk("rst_colour", colour, 0);
    chk("rst_rotation", rotation, 0);
    chk("rst_loaded", loaded, 0);
    chk("rst_err", err, 0);
    chk("rst_state", fsm_state, 0);
    do_reset();

    // rejected commands while nothing is loaded
    issue(1, 0, 0, 0);
    expect_reject(0, 0);
    issue(0, 7, 3, 3);
    expect_reject(0, 0);

    foreach (vecs[k]) begin
      v = vecs[k];
      issue(v.c, v.b, v.ox, v.oy);
      model_apply(v.c, v.b, v.ox, v.oy);
      exp_q.push_back(pack(v.x0, v.y0, 0));
      exp_q.push_back(pack(v.x1, v.y1, 1));
      exp_q.push_back(pack(v.x2, v.y2, 2));
      exp_q.push_back(pack(v.x3, v.y3, 3));
      run_stream(1'b0, v.rot, v.col);
    end

    // invalid load leaves the held I piece at (30,31) intact; redraw proves it
    issue(0, 7, 1, 1);
    expect_reject(1, 0);
    issue(3, 0, 0, 0);
    push_model_cells();
    run_stream(1'b0, 0, 'h0F);

    // Z with cell_ready 1-0-0-1, then reset in the middle of cell 2
    issue(0, 6, 10, 10);
    chk("z_valid", cell_valid, 1);
    cell_ready = 1'b1;
    chk("z_cell0", cell_now(), pack(10, 10, 0));
    @(posedge clk); #1;
    cell_ready = 1'b0;
    chk("z_cell1", cell_now(), pack(11, 10, 1));
    chk("z_colour", colour, 'h30);
    @(posedge clk); #1;
    chk("z_hold1", cell_now(), pack(11, 10, 1));
    chk("z_hold1_valid", cell_valid, 1);
    @(posedge clk); #1;
    chk("z_hold2", cell_now(), pack(11, 10, 1));
    chk("z_hold2_colour", colour, 'h30);
    cell_ready = 1'b1;
    @(posedge clk); #1;
    cell_ready = 1'b0;
    chk("z_cell2", cell_now(), pack(11, 11, 2));
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_valid", cell_valid, 0);
    chk("async_rst_cmd_ready", cmd_ready, 1);
    chk("async_rst_loaded", loaded, 0);
    chk("async_rst_cell_x", cell_x, 0);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    model_reset();
    chk("post_rst_valid", cell_valid, 0);
    chk("post_rst_loaded", loaded, 0);
    chk("post_rst_rotation", rotation, 0);

    // random commands against the model
    for (int n = 0; n < 60; n++) begin
      c = $urandom_range(0, 3);
      b = ($urandom_range(0, 7) == 0) ? 7 : $urandom_range(0, 6);
      ox = $urandom_range(0, (1 << CW) - 1);
      oy = $urandom_range(0, (1 << CW) - 1);
      if (model_accepts(c, b)) begin
        issue(c, b, ox, oy);
        model_apply(c, b, ox, oy);
        push_model_cells();
        run_stream(1'b1, m_rot, colour_tab[m_blk]);
      end else begin
        issue(c, b, ox, oy);
        expect_reject(m_loaded, m_rot);
      end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
